clock_time_keeper: RTL and testbench

Parametrised time-keeping core for the board clock. It takes raw Hour-Up and Minute-Up push-buttons and conditions them internally: two-flop synchroniser, counter debounce, rising-edge pulse and hold-to-auto-repeat. It generates its own 1 Hz tick from the system clock and keeps HH:MM:SS as BCD digits in 24 h or 12 h (AM/PM) mode. Its BCD outputs feed the seven-segment driver (HH:MM) and the seconds LEDs.

---
 rtl/clock_time_keeper.sv | 252 +++++++++++++++++++++++++
 tb/tb_clock_time_keeper.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_keeper.sv
// rtl/clock_time_keeper.sv - debounced set buttons, 1 Hz divider and BCD HH:MM:SS time keeper
//
// Purpose: keeps time of day as BCD digits in 24 h or 12 h (AM/PM) mode,
// advanced by an internally divided 1 Hz tick and set by two raw push-buttons
// that are synchronised, debounced, edge-detected and auto-repeated here.
//
// Ports:
//   i_clk          system clock, all state on rising edge
//   i_rst_n        asynchronous active-low reset
//   i_en           run enable for divider and time (setting works regardless)
//   i_clr          synchronous clear of time, divider, pending tick and pulses
//   i_btn_hr       raw Hour-Up button, active high
//   i_btn_min      raw Minute-Up button, active high
//   o_h2..o_s1     BCD tens/units of hours, minutes, seconds
//   o_pm           PM flag (12 h mode only, else 0)
//   o_tick_1hz     one-cycle pulse on each divider wrap
//   o_hr_pulse     one-cycle hour set pulse (press or repeat)
//   o_min_pulse    one-cycle minute set pulse (press or repeat)

module clock_time_keeper #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned DB_CYCLES  = 1_000_000,
  parameter int unsigned RPT_DELAY  = 50_000_000,
  parameter int unsigned RPT_PERIOD = 10_000_000,
  parameter bit          MODE_12H   = 1'b0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic       i_btn_hr,
  input  logic       i_btn_min,
  output logic [3:0] o_h2,
  output logic [3:0] o_h1,
  output logic [3:0] o_m2,
  output logic [3:0] o_m1,
  output logic [3:0] o_s2,
  output logic [3:0] o_s1,
  output logic       o_pm,
  output logic       o_tick_1hz,
  output logic       o_hr_pulse,
  output logic       o_min_pulse
);

  localparam int unsigned DIV_W    = $clog2(CLK_HZ);
  localparam int unsigned DB_W     = $clog2(DB_CYCLES + 1);
  localparam int unsigned RPT_LOAD = (RPT_DELAY == 0) ? 1 : RPT_DELAY;
  localparam int unsigned RPT_MAX  = (RPT_LOAD > RPT_PERIOD) ? RPT_LOAD : RPT_PERIOD;
  localparam int unsigned RPT_W    = $clog2(RPT_MAX + 1);
  localparam logic [7:0]  HR_RST   = MODE_12H ? 8'h12 : 8'h00;

  // Returns {wrap, next} for a 00..59 BCD field.
  function automatic logic [8:0] inc_bcd60(input logic [7:0] v);
    if (v == 8'h59)
      return {1'b1, 8'h00};
    else if (v[3:0] == 4'd9)
      return {1'b0, v[7:4] + 4'd1, 4'd0};
    else
      return {1'b0, v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [7:0] v);
    if (MODE_12H && v == 8'h12)
      return 8'h01;
    if (!MODE_12H && v == 8'h23)
      return 8'h00;
    if (v[3:0] == 4'd9)
      return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // ---------------- button conditioning (bit 1 = hour, bit 0 = minute)
  logic [1:0]       w_btn_raw;
  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       r_db;
  logic [1:0]       r_db_q;
  logic [1:0]       r_pulse;
  logic [1:0]       w_fire;
  logic [DB_W-1:0]  r_db_cnt  [2];
  logic [RPT_W-1:0] r_rpt_cnt [2];

  assign w_btn_raw = {i_btn_hr, i_btn_min};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int b = 0; b < 2; b++) begin
        r_db_cnt[b]  <= '0;
        r_rpt_cnt[b] <= '0;
      end
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int b = 0; b < 2; b++) begin
        // Any sample agreeing with the debounced level restarts the count.
        if (r_sync2[b] != r_db[b]) begin
          if (r_db_cnt[b] == DB_W'(DB_CYCLES - 1)) begin
            r_db[b]     <= ~r_db[b];
            r_db_cnt[b] <= '0;
          end else begin
            r_db_cnt[b] <= r_db_cnt[b] + 1'b1;
          end
        end else begin
          r_db_cnt[b] <= '0;
        end

        // Counter is idle at 0 while released, so a value of 1 only
        // occurs while held and marks the next repeat.
        if (r_db[b] && !r_db_q[b])
          r_rpt_cnt[b] <= RPT_W'(RPT_LOAD);
        else if (r_db[b]) begin
          if (r_rpt_cnt[b] == RPT_W'(1))
            r_rpt_cnt[b] <= RPT_W'(RPT_PERIOD);
          else
            r_rpt_cnt[b] <= r_rpt_cnt[b] - 1'b1;
        end else
          r_rpt_cnt[b] <= '0;
      end
    end
  end

  always_comb begin
    w_fire = '0;
    for (int b = 0; b < 2; b++)
      w_fire[b] = r_db[b] && (!r_db_q[b] || r_rpt_cnt[b] == RPT_W'(1));
  end

  // clr drops pulses but leaves debounce and repeat timing running.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_pulse <= '0;
    else if (i_clr)
      r_pulse <= '0;
    else
      r_pulse <= w_fire;
  end

  // ---------------- 1 Hz divider
  logic [DIV_W-1:0] r_div;
  logic             r_tick;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (i_clr) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      if (r_div == DIV_W'(CLK_HZ - 1)) begin
        r_div  <= '0;
        r_tick <= 1'b1;
      end else begin
        r_div  <= r_div + 1'b1;
        r_tick <= 1'b0;
      end
    end else begin
      r_tick <= 1'b0;
    end
  end

  // ---------------- time registers
  logic [7:0] r_hr;
  logic [7:0] r_min;
  logic [7:0] r_sec;
  logic       r_pm;
  logic       r_pend;

  logic [8:0] w_sec_inc;
  logic [8:0] w_min_inc;
  logic [7:0] w_hr_inc;
  logic       w_pm_flip;
  logic       w_tick_due;
  logic [7:0] w_hr_nxt;
  logic [7:0] w_min_nxt;
  logic [7:0] w_sec_nxt;
  logic       w_pm_nxt;
  logic       w_pend_nxt;

  assign w_sec_inc = inc_bcd60(r_sec);
  assign w_min_inc = inc_bcd60(r_min);
  assign w_hr_inc  = inc_hour(r_hr);
  assign w_pm_flip = MODE_12H && (r_hr == 8'h11);

  always_comb begin
    w_tick_due = r_tick | r_pend;
    w_hr_nxt   = r_hr;
    w_min_nxt  = r_min;
    w_sec_nxt  = r_sec;
    w_pm_nxt   = r_pm;
    w_pend_nxt = r_pend;
    if (r_pulse[0] || r_pulse[1]) begin
      // Setting wins this cycle; a coinciding tick is held for the next.
      if (r_pulse[0])
        w_min_nxt = w_min_inc[7:0];
      if (r_pulse[1]) begin
        w_hr_nxt = w_hr_inc;
        w_pm_nxt = r_pm ^ w_pm_flip;
      end
      w_pend_nxt = w_tick_due;
    end else if (w_tick_due) begin
      w_pend_nxt = 1'b0;
      w_sec_nxt  = w_sec_inc[7:0];
      if (w_sec_inc[8]) begin
        w_min_nxt = w_min_inc[7:0];
        if (w_min_inc[8]) begin
          w_hr_nxt = w_hr_inc;
          w_pm_nxt = r_pm ^ w_pm_flip;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hr   <= HR_RST;
      r_min  <= 8'h00;
      r_sec  <= 8'h00;
      r_pm   <= 1'b0;
      r_pend <= 1'b0;
    end else if (i_clr) begin
      r_hr   <= HR_RST;
      r_min  <= 8'h00;
      r_sec  <= 8'h00;
      r_pm   <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_hr   <= w_hr_nxt;
      r_min  <= w_min_nxt;
      r_sec  <= w_sec_nxt;
      r_pm   <= w_pm_nxt;
      r_pend <= w_pend_nxt;
    end
  end

  assign o_h2        = r_hr[7:4];
  assign o_h1        = r_hr[3:0];
  assign o_m2        = r_min[7:4];
  assign o_m1        = r_min[3:0];
  assign o_s2        = r_sec[7:4];
  assign o_s1        = r_sec[3:0];
  assign o_pm        = r_pm;
  assign o_tick_1hz  = r_tick;
  assign o_hr_pulse  = r_pulse[1];
  assign o_min_pulse = r_pulse[0];

endmodule

// File: tb/tb_clock_time_keeper.sv
// tb/tb_clock_time_keeper.sv - self-checking bench for clock_time_keeper in 24 h and 12 h modes

module tb_clock_time_keeper;

  localparam int CLK_HZ = 10;
  localparam int DB     = 4;
  localparam int RD     = 20;
  localparam int RP     = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, clr, btn_hr, btn_min;

  logic [3:0] a_h2, a_h1, a_m2, a_m1, a_s2, a_s1;
  logic       a_pm, a_tick, a_hp, a_mp;
  logic [3:0] b_h2, b_h1, b_m2, b_m1, b_s2, b_s1;
  logic       b_pm, b_tick, b_hp, b_mp;

  clock_time_keeper #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .RPT_DELAY(RD),
                      .RPT_PERIOD(RP), .MODE_12H(1'b0)) u24 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
    .i_btn_hr(btn_hr), .i_btn_min(btn_min),
    .o_h2(a_h2), .o_h1(a_h1), .o_m2(a_m2), .o_m1(a_m1), .o_s2(a_s2), .o_s1(a_s1),
    .o_pm(a_pm), .o_tick_1hz(a_tick), .o_hr_pulse(a_hp), .o_min_pulse(a_mp));

  clock_time_keeper #(.CLK_HZ(CLK_HZ), .DB_CYCLES(DB), .RPT_DELAY(RD),
                      .RPT_PERIOD(RP), .MODE_12H(1'b1)) u12 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_clr(clr),
    .i_btn_hr(btn_hr), .i_btn_min(btn_min),
    .o_h2(b_h2), .o_h1(b_h1), .o_m2(b_m2), .o_m1(b_m1), .o_s2(b_s2), .o_s1(b_s1),
    .o_pm(b_pm), .o_tick_1hz(b_tick), .o_hr_pulse(b_hp), .o_min_pulse(b_mp));

  logic [23:0] t24, t12;
  logic [27:0] v24, v12;
  assign t24 = {a_h2, a_h1, a_m2, a_m1, a_s2, a_s1};
  assign t12 = {b_h2, b_h1, b_m2, b_m1, b_s2, b_s1};
  assign v24 = {t24, a_pm, a_tick, a_hp, a_mp};
  assign v12 = {t12, b_pm, b_tick, b_hp, b_mp};

  int checks = 0;
  int failures = 0;

  // Reference model: time as seconds of day, divider as count of enabled
  // edges, repeat timing as age of the debounced press.
  int m_tod, m_en_cnt;
  bit m_tick, m_pend;
  bit m_pulse [2];
  bit m_s1 [2];
  bit m_s2 [2];
  bit m_db [2];
  int m_stab [2];
  int m_age [2];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [27:0] exp_vec(input bit m12);
    int hh, mm, ss, hd;
    bit pm;
    hh = m_tod / 3600;
    mm = (m_tod / 60) % 60;
    ss = m_tod % 60;
    hd = hh;
    pm = 1'b0;
    if (m12) begin
      hd = (hh % 12 == 0) ? 12 : hh % 12;
      pm = (hh >= 12);
    end
    return {4'(hd / 10), 4'(hd % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
            pm, m_tick, m_pulse[1], m_pulse[0]};
  endfunction

  task automatic model_update();
    int hh, mm, ss;
    bit eff, p;
    bit raw [2];
    if (!rst_n) begin
      m_tod = 0; m_en_cnt = 0; m_tick = 1'b0; m_pend = 1'b0;
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = 1'b0; m_s1[b] = 1'b0; m_s2[b] = 1'b0;
        m_db[b] = 1'b0; m_stab[b] = 0; m_age[b] = 0;
      end
      return;
    end
    raw[0] = btn_min;
    raw[1] = btn_hr;
    eff = m_tick | m_pend;
    if (clr) begin
      m_tod = 0;
      m_pend = 1'b0;
    end else if (m_pulse[0] || m_pulse[1]) begin
      hh = m_tod / 3600; mm = (m_tod / 60) % 60; ss = m_tod % 60;
      if (m_pulse[0]) mm = (mm + 1) % 60;
      if (m_pulse[1]) hh = (hh + 1) % 24;
      m_tod = hh * 3600 + mm * 60 + ss;
      m_pend = eff;
    end else if (eff) begin
      m_tod = (m_tod + 1) % 86400;
      m_pend = 1'b0;
    end
    if (clr) begin
      m_en_cnt = 0;
      m_tick = 1'b0;
    end else if (en) begin
      m_en_cnt++;
      m_tick = (m_en_cnt % CLK_HZ) == 0;
    end else
      m_tick = 1'b0;
    for (int b = 0; b < 2; b++) begin
      p = !clr && m_db[b] && (m_age[b] == 0 || (m_age[b] >= RD && (m_age[b] - RD) % RP == 0));
      m_age[b] = m_db[b] ? m_age[b] + 1 : 0;
      m_pulse[b] = p;
      if (m_s2[b] != m_db[b]) begin
        m_stab[b]++;
        if (m_stab[b] == DB) begin
          m_db[b] = ~m_db[b];
          m_stab[b] = 0;
        end
      end else
        m_stab[b] = 0;
      m_s2[b] = m_s1[b];
      m_s1[b] = raw[b];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    chk("model24", 32'(v24), 32'(exp_vec(1'b0)));
    chk("model12", 32'(v12), 32'(exp_vec(1'b1)));
  endtask

  task automatic press(input bit hr);
    if (hr) btn_hr = 1'b1; else btn_min = 1'b1;
    repeat (8) step();
    btn_hr = 1'b0;
    btn_min = 1'b0;
    repeat (8) step();
  endtask

  task automatic run(input int n);
    en = 1'b1;
    repeat (n) step();
    en = 1'b0;
    repeat (2) step();
  endtask

  typedef struct {
    int         hr_n;
    int         min_n;
    int         run_n;
    logic [23:0] e24;
    logic [23:0] e12;
    bit          e_pm;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int npls, pos, ncnt;
    int hpos [$];
    int exp_pos [5];
    bit bounce [4];
    int len_hr, len_min;

    tbl[0]  = '{0,  0,  0,   24'h000000, 24'h120000, 1'b0};
    tbl[1]  = '{1,  2,  0,   24'h010200, 24'h010200, 1'b0};
    tbl[2]  = '{11, 0,  0,   24'h120200, 24'h120200, 1'b1};
    tbl[3]  = '{0,  0,  30,  24'h120203, 24'h120203, 1'b1};
    tbl[4]  = '{12, 0,  0,   24'h000203, 24'h120203, 1'b0};
    tbl[5]  = '{23, 58, 0,   24'h230003, 24'h110003, 1'b1};
    tbl[6]  = '{0,  59, 0,   24'h235903, 24'h115903, 1'b1};
    tbl[7]  = '{0,  0,  570, 24'h000000, 24'h120000, 1'b0};
    tbl[8]  = '{11, 59, 590, 24'h115959, 24'h115959, 1'b0};
    tbl[9]  = '{0,  0,  10,  24'h120000, 24'h120000, 1'b1};
    tbl[10] = '{1,  0,  0,   24'h130000, 24'h010000, 1'b1};

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; btn_hr = 1'b0; btn_min = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (2) step();

    // Table: presses with time frozen, then an enabled run.
    for (int i = 0; i < 11; i++) begin
      for (int k = 0; k < tbl[i].hr_n; k++) press(1'b1);
      for (int k = 0; k < tbl[i].min_n; k++) press(1'b0);
      if (tbl[i].run_n > 0) run(tbl[i].run_n);
      chk($sformatf("tbl%0d_24", i), 32'(t24), 32'(tbl[i].e24));
      chk($sformatf("tbl%0d_12", i), 32'(t12), 32'(tbl[i].e12));
      chk($sformatf("tbl%0d_pm", i), 32'(b_pm), 32'(tbl[i].e_pm));
    end

    // Bouncing minute button: one pulse, six cycles after the steady edge.
    bounce[0] = 1'b1; bounce[1] = 1'b0; bounce[2] = 1'b1; bounce[3] = 1'b0;
    npls = 0; pos = -1;
    for (int j = 0; j < 4; j++) begin
      btn_min = bounce[j];
      step();
      if (a_mp) npls++;
    end
    btn_min = 1'b1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (a_mp) begin npls++; pos = j; end
    end
    btn_min = 1'b0;
    for (int j = 0; j < 10; j++) begin
      step();
      if (a_mp) npls++;
    end
    chk("db_count", 32'(npls), 32'd1);
    chk("db_pos", 32'(pos), 32'd6);
    chk("db_time24", 32'(t24), 32'h130100);
    chk("db_time12", 32'(t12), 32'h010100);

    // Auto-repeat from 05.
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_24", 32'(t24), 32'h000000);
    chk("clr_12", 32'(t12), 32'h120000);
    for (int k = 0; k < 5; k++) press(1'b1);
    btn_hr = 1'b1;
    for (int j = 0; j < 55; j++) begin
      if (j == 40) btn_hr = 1'b0;
      step();
      if (a_hp) hpos.push_back(j);
    end
    exp_pos[0] = 6; exp_pos[1] = 26; exp_pos[2] = 31; exp_pos[3] = 36; exp_pos[4] = 41;
    chk("rpt_count", 32'(hpos.size()), 32'd5);
    for (int k = 0; k < 5 && k < hpos.size(); k++)
      chk($sformatf("rpt_pos%0d", k), 32'(hpos[k]), 32'(exp_pos[k]));
    chk("rpt_hr24", 32'(t24), 32'h100000);
    chk("rpt_hr12", 32'(t12), 32'h100000);

    // Minute set coinciding with a tick at 00:10:59.
    clr = 1'b1; step(); clr = 1'b0;
    for (int k = 0; k < 10; k++) press(1'b0);
    en = 1'b1;
    repeat (593) step();
    btn_min = 1'b1;
    repeat (6) step();
    step();
    chk("col_tick", 32'(a_tick), 32'd1);
    chk("col_mp", 32'(a_mp), 32'd1);
    chk("col_t0", 32'(t24), 32'h001059);
    step();
    chk("col_t1", 32'(t24), 32'h001159);
    step();
    chk("col_t2", 32'(t24), 32'h001200);
    chk("col_t2_12", 32'(t12), 32'h121200);
    btn_min = 1'b0; en = 1'b0;
    repeat (10) step();

    // en=0 for 50 cycles: frozen, but setting still applies.
    ncnt = 0;
    btn_hr = 1'b1;
    for (int j = 0; j < 50; j++) begin
      if (j == 8) btn_hr = 1'b0;
      step();
      if (a_tick) ncnt++;
    end
    chk("en0_ticks", 32'(ncnt), 32'd0);
    chk("en0_t24", 32'(t24), 32'h011200);

    // clr mid-count restarts the divider from 0.
    en = 1'b1;
    repeat (25) step();
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr2_24", 32'(t24), 32'h000000);
    chk("clr2_12", 32'(t12), 32'h120000);
    chk("clr2_tick", 32'(a_tick), 32'd0);
    ncnt = 0; pos = -1;
    for (int j = 0; j < 10; j++) begin
      step();
      if (a_tick) begin ncnt++; pos = j; end
    end
    chk("clr2_tcnt", 32'(ncnt), 32'd1);
    chk("clr2_tpos", 32'(pos), 32'd9);
    en = 1'b0;
    repeat (2) step();

    // Reset in the middle of a hold.
    btn_hr = 1'b1;
    repeat (10) step();
    rst_n = 1'b0;
    step();
    btn_hr = 1'b0;
    step();
    chk("rst_24", 32'(v24), 32'h0000000);
    chk("rst_12", 32'(v12), {4'd0, 28'h1200000});
    rst_n = 1'b1;
    npls = 0;
    repeat (30) begin
      step();
      if (a_hp) npls++;
    end
    chk("rst_nopulse", 32'(npls), 32'd0);
    btn_hr = 1'b1;
    repeat (8) begin
      step();
      if (a_hp) npls++;
    end
    btn_hr = 1'b0;
    repeat (8) step();
    chk("rst_repress", 32'(npls), 32'd1);
    chk("rst_rep_24", 32'(t24), 32'h010000);

    // Random stimulus against the model.
    len_hr = 0; len_min = 0;
    for (int i = 0; i < 3000; i++) begin
      if (len_hr == 0) begin
        btn_hr = ~btn_hr;
        len_hr = $urandom_range(1, 35);
      end
      if (len_min == 0) begin
        btn_min = ~btn_min;
        len_min = $urandom_range(1, 35);
      end
      len_hr--;
      len_min--;
      en    = ($urandom_range(0, 9) != 0);
      clr   = ($urandom_range(0, 199) == 0);
      rst_n = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1; clr = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
